beat_sequencer: RTL and testbench
=================================

// Module: beat_sequencer
// PURPOSE
//  Beat (W1/W2/W3) timing generator that drives the W[3:1] inputs of the hardwired controller.
//  Consumes the controller's SHORT, LONG and STOP outputs to set machine-cycle length and halt points.
//  Consumes the QD start button to resume. Also provides a completed-cycle counter and a single-step mode.
// PARAMETERS
//  CNT_W        16   width of CYC_CNT
//  SYNC_STAGES  2    QD synchronizer depth (>=2)
//  WDOG_LIMIT   255  max machine cycles between halts (only with HDSEQ_WDOG_EN)
// PORTS
//  T3        in   1      clock; all state updates on the FALLING edge of T3
//  CLR       in   1      asynchronous reset, active-low
//  QD        in   1      start/continue button, asynchronous, active-high
//  STEP      in   1      1 = halt after every completed machine cycle
//  SHORT     in   1      from controller; sampled only in W1
//  LONG      in   1      from controller; sampled only in W2
//  STOP      in   1      from controller; sampled in any beat
//  W         out  3      one-hot beat, W[1]..W[3]; 3'b000 when halted
//  RUN       out  1      1 while sequencing
//  CYC_CNT   out  CNT_W  completed machine cycles, wraps modulo 2^CNT_W
//  WDOG_TRIP out  1      sticky watchdog flag (tied 0 without HDSEQ_WDOG_EN)
// BEHAVIOUR
//  Reset (CLR=0, async): state HALT, W=000, RUN=0, CYC_CNT=0, WDOG_TRIP=0.
//   Sync flops reset to 0. Edge-detect history flop resets to 1, so QD held through reset does NOT start.
//  QD path: SYNC_STAGES flops, then a rising-edge detect (qd_s & ~qd_prev).
//   Latency from QD rise to W=001 is SYNC_STAGES+1 falling edges.
//  States: HALT, B1, B2, B3 (W = 000/001/010/100). Transitions at each falling T3 edge, in priority order:
//   HALT: qd_rise -> B1; else stay.
//   B1: STOP -> HALT; else SHORT -> (STEP ? HALT : B1); else B2.
//   B2: STOP -> HALT; else LONG -> B3; else (STEP ? HALT : B1).
//   B3: STOP -> HALT; else (STEP ? HALT : B1).
//  A machine cycle completes when leaving its last beat: B1 with SHORT, B2 without LONG, B3, or any beat with STOP.
//   CYC_CNT += 1 on that edge. Wrap from all-ones to 0 is silent.
//  LONG in B1 and SHORT in B2/B3 are ignored. STOP beats SHORT/LONG. STOP in HALT is ignored.
//  qd_rise while RUN=1 is discarded, not queued.
//  A qd_rise on the same edge that enters HALT is also discarded; a fresh press is required.
//  Resume always restarts at B1 (next machine cycle). The controller owns any re-entry state.
//  RUN = (state != HALT), registered with the state.
//  W is a direct decode of the state register: glitch-free, changes only on falling T3 or CLR.
//  CLR mid-beat: W drops to 000 immediately. Next start needs a QD press after CLR release.
// CONFIGURATION
//  HDSEQ_WDOG_EN defined:
//   Counter wd clears in HALT and counts each completed cycle.
//   When wd reaches WDOG_LIMIT on a completion edge: force HALT, set WDOG_TRIP.
//   WDOG_TRIP is cleared only by CLR. While WDOG_TRIP=1, qd_rise still restarts.
//  Undefined: no watchdog logic; WDOG_TRIP tied 0.
// TESTING
//  Reset, QD held high before CLR release -> W stays 000, RUN=0; release/press QD -> W=001 after 3 falling edges.
//  Run, SHORT=1 every W1, STOP=0 -> W: 001,001,001...; CYC_CNT +1 per edge.
//  LONG=1 in W2 -> W sequence 001,010,100,001; CYC_CNT +1 only after W3.
//  STOP=1 during W2 -> next W=000, RUN=0, CYC_CNT +1; QD press -> resumes at W=001.
//  STEP=1, SHORT=0, LONG=0 -> 001,010,000; each QD press yields exactly one cycle; CLR asserted in W2 -> W=000 at once.
//  HDSEQ_WDOG_EN with WDOG_LIMIT=4 and no STOP -> halts after cycle 4, WDOG_TRIP=1, CYC_CNT=4; CNT_W=4 wraps 15->0.

Source files
------------

// File: rtl/beat_sequencer.sv
// beat_sequencer: W1/W2/W3 beat generator for the hardwired controller.
// Machine-cycle length follows SHORT/LONG, halts on STOP or STEP, and resumes
// on a synchronized rising edge of the QD button. Counts completed cycles.
// Optional watchdog: define HDSEQ_WDOG_EN to enable the cycles-between-halts limit.
// All state advances on the falling edge of T3; CLR is async active-low.
module beat_sequencer #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WDOG_LIMIT  = 255
) (
    input  logic             T3,
    input  logic             CLR,
    input  logic             QD,
    input  logic             STEP,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
    output logic [2:0]       W,
    output logic             RUN,
    output logic [CNT_W-1:0] CYC_CNT,
    output logic             WDOG_TRIP
);

    // One-hot beat encoding so W is the state register itself
    typedef enum logic [2:0] {
        ST_HALT = 3'b000,
        ST_B1   = 3'b001,
        ST_B2   = 3'b010,
        ST_B3   = 3'b100
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   cyc_done;
    logic [SYNC_STAGES-1:0] qd_sync;
    logic [SYNC_STAGES-1:0] sync_fill;
    logic                   qd_s;
    logic                   qd_prev;
    logic                   qd_rise;
    logic                   run_q;
    logic [CNT_W-1:0]       cyc_cnt;

    // Elaboration-time parameter sanity
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("beat_sequencer: SYNC_STAGES must be at least 2");
    end
    if (WDOG_LIMIT == 0) begin : g_bad_wdog
        $error("beat_sequencer: WDOG_LIMIT must be nonzero");
    end

    // QD synchronizer plus a fill marker that is all-ones once the chain holds real samples
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            qd_sync   <= '0;
            sync_fill <= '0;
        end else begin
            qd_sync   <= {qd_sync[SYNC_STAGES-2:0], QD};
            sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign qd_s = qd_sync[SYNC_STAGES-1];

    // Edge history holds high until the chain is primed, so QD held through CLR never starts
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            qd_prev <= 1'b1;
        end else begin
            qd_prev <= sync_fill[SYNC_STAGES-1] ? qd_s : 1'b1;
        end
    end

    assign qd_rise = qd_s & ~qd_prev;

`ifdef HDSEQ_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] wd;
    logic            wd_hit;
    logic            trip_q;

    // This completion would bring the run length to the limit
    assign wd_hit = (wd >= WD_W'(WDOG_LIMIT - 1));

    // Cycles-since-halt counter and sticky trip flag
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            wd     <= '0;
            trip_q <= 1'b0;
        end else begin
            if (state == ST_HALT) begin
                wd <= '0;
            end else if (cyc_done) begin
                wd <= wd + WD_W'(1);
            end
            if (cyc_done && wd_hit) begin
                trip_q <= 1'b1;
            end
        end
    end

    assign WDOG_TRIP = trip_q;
`else
    assign WDOG_TRIP = 1'b0;
`endif

    // Beat state register
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            state <= ST_HALT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next beat and machine-cycle completion
    always_comb begin
        state_nxt = state;
        cyc_done  = 1'b0;
        case (state)
            ST_HALT: begin
                if (qd_rise) begin
                    state_nxt = ST_B1;
                end
            end
            ST_B1: begin
                if (STOP) begin
                    state_nxt = ST_HALT;
                    cyc_done  = 1'b1;
                end else if (SHORT) begin
                    state_nxt = STEP ? ST_HALT : ST_B1;
                    cyc_done  = 1'b1;
                end else begin
                    state_nxt = ST_B2;
                end
            end
            ST_B2: begin
                if (STOP) begin
                    state_nxt = ST_HALT;
                    cyc_done  = 1'b1;
                end else if (LONG) begin
                    state_nxt = ST_B3;
                end else begin
                    state_nxt = STEP ? ST_HALT : ST_B1;
                    cyc_done  = 1'b1;
                end
            end
            ST_B3: begin
                state_nxt = (STOP || STEP) ? ST_HALT : ST_B1;
                cyc_done  = 1'b1;
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
`ifdef HDSEQ_WDOG_EN
        if (cyc_done && wd_hit) begin
            state_nxt = ST_HALT;
        end
`endif
    end

    // RUN flag registered alongside the state
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            run_q <= 1'b0;
        end else begin
            run_q <= (state_nxt != ST_HALT);
        end
    end

    // Completed machine-cycle counter, wraps silently
    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            cyc_cnt <= '0;
        end else if (cyc_done) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
        end
    end

    assign W       = state;
    assign RUN     = run_q;
    assign CYC_CNT = cyc_cnt;

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: behavioural model compared every rising T3,
// plus hand-computed spot checks. Build with HDSEQ_WDOG_EN for the watchdog variant.
module tb_beat_sequencer;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned WDOG_LIMIT  = 4;

    logic             T3;
    logic             CLR;
    logic             QD;
    logic             STEP;
    logic             SHORT;
    logic             LONG;
    logic             STOP;
    logic [2:0]       W;
    logic             RUN;
    logic [CNT_W-1:0] CYC_CNT;
    logic             WDOG_TRIP;

    int n_checks = 0;
    int n_fail   = 0;

    beat_sequencer #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .T3       (T3),
        .CLR      (CLR),
        .QD       (QD),
        .STEP     (STEP),
        .SHORT    (SHORT),
        .LONG     (LONG),
        .STOP     (STOP),
        .W        (W),
        .RUN      (RUN),
        .CYC_CNT  (CYC_CNT),
        .WDOG_TRIP(WDOG_TRIP)
    );

    initial T3 = 1'b1;
    always #5 T3 = ~T3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_beat: 0 = halted, otherwise the 1-based beat number within the machine cycle
    bit qd_hist[$];
    int m_beat = 0;
    int m_cnt  = 0;
    int m_wd   = 0;
    bit m_trip = 1'b0;

    // QD as sampled at falling edge idx (1-based since reset); dflt before that
    function automatic bit qd_at(int idx, bit dflt);
        if (idx < 1) return dflt;
        return qd_hist[idx-1];
    endfunction

    always @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            m_beat = 0;
            m_cnt  = 0;
            m_wd   = 0;
            m_trip = 1'b0;
            qd_hist.delete();
        end else begin
            int k;
            bit rise;
            bit ends;
            qd_hist.push_back(QD);
            k    = qd_hist.size();
            rise = qd_at(k - SYNC_STAGES, 1'b0) & ~qd_at(k - SYNC_STAGES - 1, 1'b1);
            if (m_beat == 0) begin
                m_wd = 0;
                if (rise) m_beat = 1;
            end else begin
                ends = STOP || (m_beat == 1 && SHORT) || (m_beat == 2 && !LONG) || (m_beat == 3);
                if (!ends) begin
                    m_beat = m_beat + 1;
                end else begin
                    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                    m_beat = (STOP || STEP) ? 0 : 1;
`ifdef HDSEQ_WDOG_EN
                    m_wd = m_wd + 1;
                    if (m_wd >= WDOG_LIMIT) begin
                        m_beat = 0;
                        m_trip = 1'b1;
                    end
`endif
                end
            end
        end
    end

    // Compare DUT against model on the non-active edge
    always @(posedge T3) begin
        logic [2:0] exp_w;
        exp_w = (m_beat == 0) ? 3'b000 : 3'(1 << (m_beat - 1));
        chk("model_w",    32'(W),         32'(exp_w));
        chk("model_run",  32'(RUN),       32'(m_beat != 0));
        chk("model_cnt",  32'(CYC_CNT),   32'(m_cnt));
        chk("model_trip", 32'(WDOG_TRIP), 32'(m_trip));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge T3);
        #1;
    endtask

    task automatic press();
        QD = 1'b1;
        repeat (3) tick();
        QD = 1'b0;
    endtask

    initial begin
        CLR = 1'b0; QD = 1'b1; STEP = 1'b0; SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0;
        repeat (3) tick();
        chk("rst_w",    32'(W),         32'd0);
        chk("rst_run",  32'(RUN),       32'd0);
        chk("rst_cnt",  32'(CYC_CNT),   32'd0);
        chk("rst_trip", 32'(WDOG_TRIP), 32'd0);

        // QD held high across CLR release must not start
        CLR = 1'b1;
        repeat (6) tick();
        chk("qd_held_w",   32'(W),   32'd0);
        chk("qd_held_run", 32'(RUN), 32'd0);
        QD = 1'b0;
        repeat (4) tick();

        // Start latency and SHORT cycles
        SHORT = 1'b1; QD = 1'b1;
        tick(); tick();
        chk("lat2_w", 32'(W), 32'd0);
        tick();
        chk("lat3_w",   32'(W),   32'd1);
        chk("lat3_run", 32'(RUN), 32'd1);
        QD = 1'b0;
        repeat (3) tick();
        chk("short_cnt", 32'(CYC_CNT), 32'd3);
        chk("short_w",   32'(W),       32'd1);
        STOP = 1'b1;
        tick();
        chk("stop_b1_w",   32'(W),       32'd0);
        chk("stop_b1_run", 32'(RUN),     32'd0);
        chk("stop_b1_cnt", 32'(CYC_CNT), 32'd4);
        STOP = 1'b0; SHORT = 1'b0; LONG = 1'b1;

        // LONG cycle: 001,010,100,001
        press();
        chk("long_start_w", 32'(W), 32'd1);
        tick(); chk("long_w2", 32'(W), 32'd2);
        tick(); chk("long_w3", 32'(W), 32'd4);
        chk("long_cnt_mid", 32'(CYC_CNT), 32'd4);
        tick(); chk("long_w1", 32'(W), 32'd1);
        chk("long_cnt_end", 32'(CYC_CNT), 32'd5);

        // QD press while running is discarded; STOP in W2 halts
        LONG = 1'b0; QD = 1'b1;
        tick(); chk("run_w2", 32'(W), 32'd2);
        tick(); chk("run_w1", 32'(W), 32'd1);
        chk("run_cnt", 32'(CYC_CNT), 32'd6);
        tick(); chk("qd_run_ignored_w", 32'(W), 32'd2);
        STOP = 1'b1;
        tick();
        chk("stop_b2_w",   32'(W),       32'd0);
        chk("stop_b2_run", 32'(RUN),     32'd0);
        chk("stop_b2_cnt", 32'(CYC_CNT), 32'd7);
        STOP = 1'b0; QD = 1'b0;
        repeat (3) tick();

        // Rise landing on the halting edge is dropped
        SHORT = 1'b1;
        press();
        chk("resume_w", 32'(W), 32'd1);
        tick();
        QD = 1'b1;
        tick(); tick();
        STOP = 1'b1;
        tick();
        chk("halt_edge_w",   32'(W),       32'd0);
        chk("halt_edge_cnt", 32'(CYC_CNT), 32'd11);
        STOP = 1'b0; SHORT = 1'b0;
        repeat (4) tick();
        chk("halt_edge_rise_dropped", 32'(W), 32'd0);
        QD = 1'b0;
        repeat (3) tick();

        // Single-step: 001,010,000 per press
        STEP = 1'b1;
        press();
        chk("step_w1", 32'(W), 32'd1);
        tick(); chk("step_w2", 32'(W), 32'd2);
        tick();
        chk("step_halt_w",   32'(W),       32'd0);
        chk("step_halt_cnt", 32'(CYC_CNT), 32'd12);
        repeat (3) tick();
        press(); tick(); tick();
        chk("step2_w",   32'(W),       32'd0);
        chk("step2_cnt", 32'(CYC_CNT), 32'd13);
        repeat (3) tick();
        press(); tick();
        chk("step3_w2", 32'(W), 32'd2);
        #2 CLR = 1'b0;
        #1;
        chk("clr_mid_w",   32'(W),       32'd0);
        chk("clr_mid_run", 32'(RUN),     32'd0);
        chk("clr_mid_cnt", 32'(CYC_CNT), 32'd0);
        repeat (2) tick();
        CLR = 1'b1; STEP = 1'b0; SHORT = 1'b1;
        repeat (4) tick();
        chk("clr_needs_press", 32'(W), 32'd0);

        press();
        chk("final_start_w", 32'(W), 32'd1);
`ifdef HDSEQ_WDOG_EN
        repeat (4) tick();
        chk("wdog_w",    32'(W),         32'd0);
        chk("wdog_run",  32'(RUN),       32'd0);
        chk("wdog_cnt",  32'(CYC_CNT),   32'd4);
        chk("wdog_trip", 32'(WDOG_TRIP), 32'd1);
        repeat (3) tick();
        press();
        chk("wdog_restart_w",    32'(W),         32'd1);
        chk("wdog_restart_trip", 32'(WDOG_TRIP), 32'd1);
`else
        repeat (18) tick();
        chk("wrap_cnt", 32'(CYC_CNT),   32'd2);
        chk("wrap_w",   32'(W),         32'd1);
        chk("no_trip",  32'(WDOG_TRIP), 32'd0);
`endif
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
